db_lcu_rd: RTL and testbench
============================

Name: db_lcu_rd

Overview:
- Read-side controller for the deblocking LCU pixel memory port: cen/ren/wen active-low, 1-cycle registered read latency.
- Given a base address and word count, it issues sequential reads on one RAM port. It captures the returned words and streams them downstream over a valid/ready handshake.
- It uses a 2-entry output buffer and credit-based read issue, so backpressure never loses a word already in flight.
- Sits between the LCU RAM and the deblocking filter datapath.

Parameters:
- DATA_WIDTH, 128, RAM word width (16 pixels x 8 bits)
- ADDR_WIDTH, 8, RAM address width
- LEN_WIDTH, 9, width of word-count input (up to 256 words)

Ports:
- clk  input  1  clock, same clock as RAM port
- rst_n  input  1  asynchronous active-low reset
- start_i  input  1  one-cycle request pulse
- base_addr_i  input  ADDR_WIDTH  first address, sampled when start_i is accepted
- len_i  input  LEN_WIDTH  number of words to read, sampled with start_i
- busy_o  output  1  high from accepted start until done_o
- done_o  output  1  one-cycle pulse when the last word is handed off downstream
- ram_cen_o  output  1  RAM chip enable, active low
- ram_ren_o  output  1  RAM output enable, active low
- ram_wen_o  output  1  RAM write enable, active low; tied high (read-only master)
- ram_addr_o  output  ADDR_WIDTH  RAM address
- ram_data_i  input  DATA_WIDTH  RAM read data, valid the cycle after a read issue
- data_o  output  DATA_WIDTH  streamed word (head of buffer)
- valid_o  output  1  data_o valid
- ready_i  input  1  downstream accepts when valid_o and ready_i are both high

Behaviour:
- Reset values (asynchronous, rst_n low): ram_cen_o=1, ram_ren_o=1, ram_wen_o=1, ram_addr_o=0, valid_o=0, data_o=0, busy_o=0, done_o=0. Buffer is emptied, counters are cleared, FSM enters IDLE.
- Reset mid-transfer aborts the transfer immediately:
  - no done_o pulse;
  - a read still in flight is discarded.
- FSM states:
  - IDLE: start_i accepted only here.
    - len_i != 0: latch address and count, busy_o=1, go to ISSUE.
    - len_i == 0: busy_o stays 0, done_o pulses the next cycle, no RAM access.
  - ISSUE: issue one read per cycle while credit allows. Go to DRAIN after the last issue.
  - DRAIN: wait until the in-flight read has landed and the buffer is empty. Then pulse done_o for one cycle, drop busy_o in that same cycle, and return to IDLE.
- start_i while busy_o=1 is ignored, with no effect on the current transfer.
- Read issue cycle: ram_cen_o=0, ram_addr_o=current address.
  - Address increments by 1 per issue, modulo 2^ADDR_WIDTH; 255 wraps to 0.
  - ram_cen_o=1 on every cycle without an issue.
- Cycle after an issue:
  - ram_ren_o=0 and the word on ram_data_i is written into the buffer;
  - ram_ren_o=1 otherwise.
- Credit rule: issue only if buffer_count + inflight - pop < 2, where pop = valid_o & ready_i in the current cycle. inflight is at most 1. With ready_i held high, throughput is 1 word per clock.
- Buffer behaviour:
  - 2-entry FIFO; data_o and valid_o come straight from the head register.
  - Push and pop in the same cycle are allowed at any occupancy.
  - Overflow is impossible by the credit rule.
- Output holding:
  - data_o holds stable while valid_o=1 and ready_i=0.
  - data_o holds its last value when the buffer is empty.
- Latency: start_i at cycle T gives the first ram_cen_o=0 at T+1, the first valid_o at T+3, and done_o the cycle after the last handshake.

Decomposition:
- Shared package db_rd_pkg:
  - FSM state encoding IDLE/ISSUE/DRAIN;
  - constant BUF_DEPTH=2.
- One sub-module is natural: db_rd_skid_buf, the 2-entry DATA_WIDTH FIFO with push/pop/count, instantiated once.

Test Plan:
- Basic burst: base=8'h10, len=4, ready_i=1.
  - ram_cen_o low on 4 consecutive cycles with addresses 10,11,12,13.
  - valid_o high for 4 consecutive cycles with words mem[10..13].
  - done_o pulses one cycle after the 4th handshake.
- Wrap-around: base=8'hFE, len=4.
  - Addresses FE,FF,00,01 are issued.
  - Data returns in that order.
- Backpressure: len=6, ready_i toggles 1,0,0,1,...
  - No word is lost or duplicated; data_o is stable while stalled.
  - ram_cen_o never issues while buffer_count + inflight reaches 2.
- Zero length: start_i with len=0.
  - No ram_cen_o low.
  - done_o pulses the next cycle; busy_o stays 0.
- Start while busy: a second start_i (base=8'h80) arrives mid-transfer of len=3 from 8'h20.
  - It is ignored: only 20,21,22 are read, and one done_o pulse occurs.
- Reset mid-transfer: rst_n low during cycle 2 of a len=8 burst.
  - All outputs immediately take their reset values, with no done_o pulse.
  - A new len=2 transfer after reset completes normally.

Source files
------------

// File: rtl/db_rd_pkg.sv
// Shared definitions for the deblocking LCU read-side controller:
// FSM state encoding and output buffer depth.
package db_rd_pkg;

  localparam int BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/db_rd_skid_buf.sv
// Two-entry output FIFO. The head register drives the output directly so the
// word stays stable under stall and keeps its last value once emptied.
module db_rd_skid_buf
  import db_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic [1:0]            o_count
);

  localparam logic [1:0] FULL = 2'(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [1:0]            r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_data;
          else                 r_tail <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          if (r_count == FULL) r_head <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the head advances to the older queued word.
          if (r_count == FULL) begin
            r_head <= r_tail;
            r_tail <= i_data;
          end else begin
            r_head <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_data  = r_head;
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/db_lcu_rd.sv
// Read-side controller for the deblocking LCU pixel RAM: issues sequential
// reads under a credit limit and streams the returned words over valid/ready.
module db_lcu_rd
  import db_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ram_cen_o,
  output logic                  ram_ren_o,
  output logic                  ram_wen_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output state_t                dbg_state_o
);

  // Handshake: a word transfers on every cycle where valid_o and ready_i are
  // both high; valid_o never drops and data_o never changes until that happens.

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_remain;
  logic                  r_ren;
  logic                  r_done;

  logic       w_push;
  logic       w_pop;
  logic       w_issue;
  logic [1:0] w_count;
  logic [2:0] w_occ;

  assign w_push = ~r_ren;
  assign w_pop  = valid_o & ready_i;

  // Occupancy left after this cycle, counting the word landing now; an issue
  // made now lands next cycle, so it must leave room for one more word.
  assign w_occ   = {1'b0, w_count} + {2'b00, w_push} - {2'b00, w_pop};
  assign w_issue = (r_state == ISSUE) && (w_occ < 3'(BUF_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_remain <= '0;
      r_ren    <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_ren  <= ~w_issue;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              r_addr   <= base_addr_i;
              r_remain <= len_i;
              r_state  <= ISSUE;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (w_issue) begin
            r_addr   <= r_addr + ADDR_WIDTH'(1);
            r_remain <= r_remain - LEN_WIDTH'(1);
            if (r_remain == LEN_WIDTH'(1)) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (r_ren && (w_occ == 3'd0)) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  db_rd_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (ram_data_i),
    .i_pop   (w_pop),
    .o_data  (data_o),
    .o_valid (valid_o),
    .o_count (w_count)
  );

  assign ram_cen_o   = ~w_issue;
  assign ram_ren_o   = r_ren;
  assign ram_wen_o   = 1'b1;
  assign ram_addr_o  = r_addr;
  assign busy_o      = (r_state != IDLE);
  assign done_o      = r_done;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_db_lcu_rd.sv
// Bench for db_lcu_rd: RAM model, table of transfers plus hand-written
// corner sequences, scoreboard of expected addresses and words.
module tb_db_lcu_rd;
  import db_rd_pkg::*;

  localparam int DW = 128;
  localparam int AW = 8;
  localparam int LW = 9;

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [LW-1:0] len_i;
  logic          busy_o;
  logic          done_o;
  logic          ram_cen_o;
  logic          ram_ren_o;
  logic          ram_wen_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_data_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  state_t        dbg_state;

  db_lcu_rd #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .ram_cen_o   (ram_cen_o),
    .ram_ren_o   (ram_ren_o),
    .ram_wen_o   (ram_wen_o),
    .ram_addr_o  (ram_addr_o),
    .ram_data_i  (ram_data_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset / RAM model ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem [256];
  always @(posedge clk) if (!ram_cen_o) ram_data_i <= mem[ram_addr_o];

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] addr_q[$];

  int n_chk = 0;
  int n_fail = 0;

  int cur_T, cur_len, rmode;
  int n_iss, n_hs, n_done, first_iss, first_val, last_hs, n_out;
  logic busy_seen, prev_issue, prev_stall;
  logic [DW-1:0] prev_data;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- ready driver ----------------
  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       ready_i = 1'b1;
        1:       ready_i = ((cyc % 3) == 0);
        default: ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_issue = 1'b0;
      prev_stall = 1'b0;
      n_out      = 0;
    end else begin
      logic pop_now;
      pop_now = valid_o & ready_i;
      check("ren_after_issue", DW'(ram_ren_o), DW'(!prev_issue));
      if (!ram_cen_o) begin
        check("credit", DW'((n_out - int'(pop_now)) < 2), DW'(1));
        if (addr_q.size() == 0) check("unexpected_issue", DW'(ram_addr_o), '1);
        else check("issue_addr", DW'(ram_addr_o), DW'(addr_q.pop_front()));
        n_iss++;
        if (first_iss < 0) first_iss = cyc;
      end
      if (prev_stall) begin
        check("stall_valid", DW'(valid_o), DW'(1));
        check("stall_data", data_o, prev_data);
      end
      if (pop_now) begin
        if (exp_q.size() == 0) check("unexpected_word", data_o, '1);
        else check("word", data_o, exp_q.pop_front());
        n_hs++;
        if (first_val < 0) first_val = cyc;
        last_hs = cyc;
      end
      if (done_o) begin
        n_done++;
        check("busy_at_done", DW'(busy_o), DW'(0));
        check("done_cycle", DW'(cyc), DW'((cur_len == 0) ? cur_T + 1 : last_hs + 1));
      end
      if (busy_o) busy_seen = 1'b1;
      n_out      = n_out + int'(!ram_cen_o) - int'(pop_now);
      prev_stall = valid_o & !ready_i;
      prev_data  = data_o;
      prev_issue = !ram_cen_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_xfer(input logic [AW-1:0] base, input int len, input bit push_exp);
    @(posedge clk);
    #1;
    start_i     = 1'b1;
    base_addr_i = base;
    len_i       = LW'(len);
    cur_T       = cyc;
    cur_len     = len;
    n_iss = 0; n_hs = 0; n_done = 0; first_iss = -1; first_val = -1; last_hs = -1;
    busy_seen = 1'b0;
    if (push_exp) begin
      for (int i = 0; i < len; i++) begin
        logic [AW-1:0] a;
        a = base + AW'(i);
        addr_q.push_back(a);
        exp_q.push_back(mem[a]);
      end
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
    check("busy_after_start", DW'(busy_o), DW'(len != 0));
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(posedge clk);
    check("done_count", DW'(n_done), DW'(1));
  endtask

  typedef struct {
    logic [AW-1:0] base;
    int            len;
    int            rmode;
    int            exp_issues;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    vecs[0] = '{8'h10, 4, 0, 4};
    vecs[1] = '{8'hFE, 4, 0, 4};
    vecs[2] = '{8'h40, 6, 1, 6};
    vecs[3] = '{8'h00, 0, 0, 0};
    vecs[4] = '{8'h55, 7, 2, 7};
    vecs[5] = '{8'hFF, 1, 0, 1};

    rmode = 0; cur_len = 0; cur_T = 0; last_hs = -1;
    n_iss = 0; n_hs = 0; n_done = 0; first_iss = -1; first_val = -1;
    busy_seen = 0; prev_issue = 0; prev_stall = 0; prev_data = '0; n_out = 0;
    rst_n = 1'b0; start_i = 1'b0; base_addr_i = '0; len_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          DW'({ram_cen_o, ram_ren_o, ram_wen_o, ram_addr_o, valid_o, busy_o, done_o}),
          DW'({3'b111, 8'h00, 3'b000}));
    check("reset_data", data_o, '0);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      rmode = vecs[v].rmode;
      start_xfer(vecs[v].base, vecs[v].len, 1'b1);
      wait_done(300);
      check("issues", DW'(n_iss), DW'(vecs[v].exp_issues));
      check("handshakes", DW'(n_hs), DW'(vecs[v].exp_issues));
      check("exp_q_empty", DW'(exp_q.size()), DW'(0));
      if (vecs[v].len == 0) check("busy_zero_len", DW'(busy_seen), DW'(0));
      if (vecs[v].rmode == 0 && vecs[v].len != 0) begin
        check("first_issue_lat", DW'(first_iss), DW'(cur_T + 1));
        check("first_valid_lat", DW'(first_val), DW'(cur_T + 3));
        check("throughput", DW'(last_hs - first_val), DW'(vecs[v].len - 1));
      end
    end

    // Start while busy: the second request must be ignored.
    rmode = 0;
    start_xfer(8'h20, 3, 1'b1);
    @(posedge clk);
    #1;
    start_i = 1'b1; base_addr_i = 8'h80; len_i = LW'(5);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done(100);
    repeat (6) @(posedge clk);
    check("busy_start_issues", DW'(n_iss), DW'(3));
    check("busy_start_dones", DW'(n_done), DW'(1));
    check("busy_start_q", DW'(addr_q.size()), DW'(0));

    // Reset in the middle of a burst.
    start_xfer(8'h30, 8, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_outputs",
          DW'({ram_cen_o, ram_ren_o, ram_wen_o, ram_addr_o, valid_o, busy_o, done_o}),
          DW'({3'b111, 8'h00, 3'b000}));
    check("midreset_data", data_o, '0);
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    check("no_done_after_reset", DW'(n_done), DW'(0));
    check("idle_after_reset", DW'(busy_o), DW'(0));
    start_xfer(8'hA0, 2, 1'b1);
    wait_done(100);
    check("post_reset_issues", DW'(n_iss), DW'(2));
    check("post_reset_words", DW'(n_hs), DW'(2));
    check("wen_high", DW'(ram_wen_o), DW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
